// File: rtl/fetch_pkg.sv
// Shared widths, PC step and buffer entry layout for the instruction fetch unit.
package fetch_pkg;

    localparam int PC_W   = 17;
    localparam int INST_W = 32;

    localparam logic [PC_W-1:0] PC_INC      = 17'd4;
    localparam logic [PC_W-1:0] PC_LOW_MASK = 17'h00003;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [PC_W-1:0]   pc;
    } buf_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Circular instruction FIFO with flush; head entry is presented combinationally.
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  buf_entry_t               push_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     head_valid,
    output buf_entry_t               head_data
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    buf_entry_t        mem [DEPTH];
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) begin
                tail_d = (tail_q == PTR_W'(DEPTH - 1)) ? '0 : tail_q + 1'b1;
            end
            if (pop) begin
                head_d = (head_q == PTR_W'(DEPTH - 1)) ? '0 : head_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage carries no reset so it maps onto plain distributed RAM.
    always_ff @(posedge clock) begin
        if (push && !flush) begin
            mem[tail_q] <= push_data;
        end
    end

    assign count      = count_q;
    assign head_valid = (count_q != '0);
    assign head_data  = mem[head_q];

endmodule

// File: rtl/fetch_unit.sv
// Sequential instruction fetch with redirect and a small decoupling buffer.
// Optional FETCH_MISALIGN_TRAP_EN: misaligned redirects raise fetch_fault and stall.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC  = 17'h00000,
    parameter int              BUF_DEPTH = 2
) (
    input  logic              clock,
    input  logic              reset_n,
    output logic [PC_W-1:0]   imem_addr,
    input  logic [INST_W-1:0] imem_inst,
    input  logic              redirect_valid,
    input  logic [PC_W-1:0]   redirect_pc,
    output logic              if_valid,
    input  logic              if_ready,
    output logic [INST_W-1:0] if_inst,
    output logic [PC_W-1:0]   if_pc,
    output logic              fetch_fault
);

    localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

    logic [CNT_W-1:0] count;
    logic             head_valid;
    logic             pop;
    logic             fetch;
    buf_entry_t       head_entry;
    buf_entry_t       push_entry;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [PC_W-1:0]  redirect_tgt;
    logic             redirect_bad;
    logic             fault_q;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic fault_d;

    assign redirect_tgt = redirect_pc;
    assign redirect_bad = |redirect_pc[1:0];

    // Every redirect re-evaluates the fault, so an aligned one clears it.
    always_comb begin
        fault_d = fault_q;
        if (redirect_valid) begin
            fault_d = redirect_bad;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_d;
        end
    end
`else
    assign redirect_tgt = redirect_pc & ~PC_LOW_MASK;
    assign redirect_bad = 1'b0;
    assign fault_q      = 1'b0;
`endif

    assign pop   = head_valid && if_ready && !redirect_valid;
    assign fetch = !redirect_valid && !fault_q && ((count < CNT_W'(BUF_DEPTH)) || pop);

    always_comb begin
        pc_d = pc_q;
        if (redirect_valid) begin
            if (!redirect_bad) begin
                pc_d = redirect_tgt;
            end
        end else if (fetch) begin
            pc_d = pc_q + PC_INC;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign push_entry = '{inst: imem_inst, pc: pc_q};

    fetch_buffer #(
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clock      (clock),
        .reset_n    (reset_n),
        .push       (fetch),
        .pop        (pop),
        .flush      (redirect_valid),
        .push_data  (push_entry),
        .count      (count),
        .head_valid (head_valid),
        .head_data  (head_entry)
    );

    assign imem_addr   = pc_q;
    assign if_valid    = head_valid;
    assign if_inst     = head_entry.inst;
    assign if_pc       = head_entry.pc;
    assign fetch_fault = fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: per-cycle vector table plus scoreboard of accepted instructions.
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam int              BUF_DEPTH = 2;
    localparam logic [PC_W-1:0] RESET_PC  = 17'h00000;

    logic              clock;
    logic              reset_n;
    logic [PC_W-1:0]   imem_addr;
    logic [INST_W-1:0] imem_inst;
    logic              redirect_valid;
    logic [PC_W-1:0]   redirect_pc;
    logic              if_valid;
    logic              if_ready;
    logic [INST_W-1:0] if_inst;
    logic [PC_W-1:0]   if_pc;
    logic              fetch_fault;

    fetch_unit #(
        .RESET_PC  (RESET_PC),
        .BUF_DEPTH (BUF_DEPTH)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .imem_addr      (imem_addr),
        .imem_inst      (imem_inst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_inst        (if_inst),
        .if_pc          (if_pc),
        .fetch_fault    (fetch_fault)
    );

    // Memory word i holds the value i.
    assign imem_inst = {17'd0, imem_addr[16:2]};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    logic [PC_W-1:0] exp_q [$];

    typedef struct {
        logic            ready;
        logic            redir;
        logic [PC_W-1:0] rpc;
        logic            exp_valid;
        logic            chk_pc;
        logic [PC_W-1:0] exp_pc;
        logic [PC_W-1:0] exp_addr;
    } vec_t;

    vec_t vecs [18];

    function automatic vec_t mk(input logic rdy, input logic rd, input logic [PC_W-1:0] rpc,
                                input logic ev, input logic cp, input logic [PC_W-1:0] epc,
                                input logic [PC_W-1:0] ea);
        vec_t v;
        v.ready = rdy; v.redir = rd; v.rpc = rpc;
        v.exp_valid = ev; v.chk_pc = cp; v.exp_pc = epc; v.exp_addr = ea;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic expect_from(input logic [PC_W-1:0] start);
        exp_q.delete();
        for (int i = 0; i < 32; i++) exp_q.push_back(start + PC_W'(4 * i));
    endtask

    // Scores any handshake pending before the edge, then advances one cycle.
    task automatic tick();
        logic [PC_W-1:0] e;
        #1;
        if (reset_n && if_valid && if_ready && !redirect_valid) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_underflow: got pc %h expected no transfer", if_pc);
            end else begin
                e = exp_q.pop_front();
                check("sb_pc", 32'(if_pc), 32'(e));
                check("sb_inst", if_inst, {17'd0, e[16:2]});
            end
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [PC_W-1:0] held_addr;

        //          rdy  rd   rpc        ev   cp   exp_pc     exp_addr
        vecs[0]  = mk(1, 0, 17'h00000, 1, 1, 17'h00000, 17'h00004);
        vecs[1]  = mk(1, 0, 17'h00000, 1, 1, 17'h00004, 17'h00008);
        vecs[2]  = mk(1, 0, 17'h00000, 1, 1, 17'h00008, 17'h0000C);
        vecs[3]  = mk(0, 0, 17'h00000, 1, 1, 17'h00008, 17'h00010);
        vecs[4]  = mk(0, 0, 17'h00000, 1, 1, 17'h00008, 17'h00010);
        vecs[5]  = mk(1, 0, 17'h00000, 1, 1, 17'h0000C, 17'h00014);
        vecs[6]  = mk(1, 0, 17'h00000, 1, 1, 17'h00010, 17'h00018);
        vecs[7]  = mk(1, 1, 17'h00100, 0, 0, 17'h00000, 17'h00100);
        vecs[8]  = mk(1, 0, 17'h00000, 1, 1, 17'h00100, 17'h00104);
        vecs[9]  = mk(1, 0, 17'h00000, 1, 1, 17'h00104, 17'h00108);
        vecs[10] = mk(1, 1, 17'h1FFF8, 0, 0, 17'h00000, 17'h1FFF8);
        vecs[11] = mk(1, 0, 17'h00000, 1, 1, 17'h1FFF8, 17'h1FFFC);
        vecs[12] = mk(1, 0, 17'h00000, 1, 1, 17'h1FFFC, 17'h00000);
        vecs[13] = mk(1, 0, 17'h00000, 1, 1, 17'h00000, 17'h00004);
        vecs[14] = mk(0, 1, 17'h00040, 0, 0, 17'h00000, 17'h00040);
        vecs[15] = mk(0, 0, 17'h00000, 1, 1, 17'h00040, 17'h00044);
        vecs[16] = mk(0, 0, 17'h00000, 1, 1, 17'h00040, 17'h00048);
        vecs[17] = mk(0, 0, 17'h00000, 1, 1, 17'h00040, 17'h00048);

        reset_n        = 1'b0;
        if_ready       = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_valid", 32'(if_valid), 32'd0);
        check("rst_fault", 32'(fetch_fault), 32'd0);
        check("rst_addr", 32'(imem_addr), 32'(RESET_PC));

        expect_from(RESET_PC);
        reset_n = 1'b1;

        for (int i = 0; i < 18; i++) begin
            if_ready       = vecs[i].ready;
            redirect_valid = vecs[i].redir;
            redirect_pc    = vecs[i].rpc;
            if (vecs[i].redir) expect_from(vecs[i].rpc);
            tick();
            redirect_valid = 1'b0;
            check($sformatf("v%0d_valid", i), 32'(if_valid), 32'(vecs[i].exp_valid));
            if (vecs[i].chk_pc) check($sformatf("v%0d_pc", i), 32'(if_pc), 32'(vecs[i].exp_pc));
            check($sformatf("v%0d_addr", i), 32'(imem_addr), 32'(vecs[i].exp_addr));
        end

        // Reset pulse with a full buffer: head must vanish before any edge.
        reset_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(if_valid), 32'd0);
        check("async_rst_addr", 32'(imem_addr), 32'(RESET_PC));
        @(posedge clock);
        #1;
        expect_from(RESET_PC);
        if_ready = 1'b0;
        reset_n  = 1'b1;

        for (int c = 0; c < 5; c++) begin
            tick();
            check($sformatf("stall%0d_valid", c), 32'(if_valid), 32'd1);
            check($sformatf("stall%0d_pc", c), 32'(if_pc), 32'(RESET_PC));
            check($sformatf("stall%0d_inst", c), if_inst, {17'd0, RESET_PC[16:2]});
        end
        check("stall_addr", 32'(imem_addr), 32'(RESET_PC + PC_W'(4 * BUF_DEPTH)));

        if_ready = 1'b1;
        tick();
        check("drain_pc", 32'(if_pc), 32'(RESET_PC + PC_W'(4)));
        tick();
        check("drain2_pc", 32'(if_pc), 32'(RESET_PC + PC_W'(8)));

        // Misaligned redirect.
        redirect_valid = 1'b1;
        redirect_pc    = 17'h00102;
        held_addr      = imem_addr;
`ifdef FETCH_MISALIGN_TRAP_EN
        exp_q.delete();
        tick();
        redirect_valid = 1'b0;
        check("mis_fault", 32'(fetch_fault), 32'd1);
        check("mis_valid", 32'(if_valid), 32'd0);
        check("mis_addr", 32'(imem_addr), 32'(held_addr));
        tick();
        tick();
        check("mis_hold_fault", 32'(fetch_fault), 32'd1);
        check("mis_hold_valid", 32'(if_valid), 32'd0);
        check("mis_hold_addr", 32'(imem_addr), 32'(held_addr));
        redirect_valid = 1'b1;
        redirect_pc    = 17'h00200;
        expect_from(17'h00200);
        tick();
        redirect_valid = 1'b0;
        check("clr_fault", 32'(fetch_fault), 32'd0);
        check("clr_valid", 32'(if_valid), 32'd0);
        check("clr_addr", 32'(imem_addr), 32'h00200);
        tick();
        check("resume_valid", 32'(if_valid), 32'd1);
        check("resume_pc", 32'(if_pc), 32'h00200);
        tick();
        check("resume2_pc", 32'(if_pc), 32'h00204);
`else
        expect_from(17'h00100);
        tick();
        redirect_valid = 1'b0;
        check("mis_fault", 32'(fetch_fault), 32'd0);
        check("mis_valid", 32'(if_valid), 32'd0);
        check("mis_addr", 32'(imem_addr), 32'h00100);
        if (held_addr == 17'h00100) check("mis_addr_moved", 32'(held_addr), 32'h0);
        tick();
        check("mis_fetch_valid", 32'(if_valid), 32'd1);
        check("mis_fetch_pc", 32'(if_pc), 32'h00100);
        check("mis_fetch_fault", 32'(fetch_fault), 32'd0);
        tick();
        check("mis_fetch2_pc", 32'(if_pc), 32'h00104);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
